// File: rtl/conv_enc_if.sv
// Byte-in / symbol-out stream bundle for conv_encoder_k3.
// The slave modport is the encoder's view; master is the view of whatever drives it.
interface conv_enc_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] encoded_bits;
  logic       out_valid;
  logic       out_ready;
  logic       out_frame_start;
  logic       out_frame_end;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, encoded_bits, out_valid, out_frame_start, out_frame_end
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, encoded_bits, out_valid, out_frame_start, out_frame_end
  );
endinterface

// File: rtl/conv_encoder_k3.sv
// Rate-1/2 K=3 convolutional encoder (g0=111, g1=101): serializes bytes MSB first into framed symbols.
// Define CONV_ENC_TAIL_FLUSH_EN to end each frame with two zero-input symbols that flush the state to 00.
module conv_encoder_k3 #(
  parameter int unsigned FRAME_BYTES = 4
) (
  input  logic        clk,
  input  logic        rst,
  conv_enc_if.slave   bus
);

`ifdef CONV_ENC_TAIL_FLUSH_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_TAIL = 2'd2} state_e;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1} state_e;
`endif

  localparam logic [7:0] LAST_BYTE = 8'(FRAME_BYTES - 1);

  // s = {older bit, newer bit}
  function automatic logic [1:0] enc_sym(input logic u, input logic [1:0] s);
    return {u ^ s[1] ^ s[0], u ^ s[1]};
  endfunction

  state_e     state_q, state_d;
  logic [6:0] byte_q, byte_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] byte_cnt_q, byte_cnt_d;
  logic [1:0] s_q, s_d;
  logic [1:0] sym_q, sym_d;
  logic       valid_q, valid_d;
  logic       fs_q, fs_d;
  logic       fe_q, fe_d;
`ifdef CONV_ENC_TAIL_FLUSH_EN
  logic       tail_cnt_q, tail_cnt_d;
`endif

  logic slot_free_s, in_ready_s, accept_s, load_s, u_s, last_byte_s;

  assign slot_free_s = !valid_q || bus.out_ready;
  assign in_ready_s  = (state_q == ST_IDLE) && slot_free_s && !rst;
  assign accept_s    = bus.in_valid && in_ready_s;
  assign last_byte_s = (byte_cnt_q == LAST_BYTE);

  assign bus.in_ready        = in_ready_s;
  assign bus.encoded_bits    = sym_q;
  assign bus.out_valid       = valid_q;
  assign bus.out_frame_start = fs_q;
  assign bus.out_frame_end   = fe_q;

  // Next-state, symbol selection and output-register load
  always_comb begin
    state_d    = state_q;
    byte_d     = byte_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    s_d        = s_q;
    sym_d      = sym_q;
    valid_d    = valid_q;
    fs_d       = fs_q;
    fe_d       = fe_q;
`ifdef CONV_ENC_TAIL_FLUSH_EN
    tail_cnt_d = tail_cnt_q;
`endif
    load_s     = 1'b0;
    u_s        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          load_s    = 1'b1;
          u_s       = bus.in_data[7];
          byte_d    = bus.in_data[6:0];
          bit_cnt_d = 3'd6;
          fs_d      = (byte_cnt_q == 8'd0);
          fe_d      = 1'b0;
          state_d   = ST_SHIFT;
        end else begin
          load_s = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (slot_free_s) begin
          load_s = 1'b1;
          u_s    = byte_q[bit_cnt_q];
          fs_d   = 1'b0;
          if (bit_cnt_q == 3'd0) begin
            byte_cnt_d = last_byte_s ? 8'd0 : byte_cnt_q + 8'd1;
`ifdef CONV_ENC_TAIL_FLUSH_EN
            fe_d    = 1'b0;
            state_d = last_byte_s ? ST_TAIL : ST_IDLE;
`else
            fe_d    = last_byte_s;
            state_d = ST_IDLE;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q - 3'd1;
            fe_d      = 1'b0;
          end
        end else begin
          load_s = 1'b0;
        end
      end
`ifdef CONV_ENC_TAIL_FLUSH_EN
      ST_TAIL: begin
        if (slot_free_s) begin
          load_s = 1'b1;
          u_s    = 1'b0;
          fs_d   = 1'b0;
          fe_d   = tail_cnt_q;
          if (tail_cnt_q) begin
            tail_cnt_d = 1'b0;
            state_d    = ST_IDLE;
          end else begin
            tail_cnt_d = 1'b1;
          end
        end else begin
          load_s = 1'b0;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A freed slot with nothing new to load drops the output
    if (load_s) begin
      sym_d   = enc_sym(u_s, s_q);
      s_d     = {s_q[0], u_s};
      valid_d = 1'b1;
    end else if (slot_free_s) begin
      valid_d = 1'b0;
      fs_d    = 1'b0;
      fe_d    = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      byte_q     <= 7'd0;
      bit_cnt_q  <= 3'd0;
      byte_cnt_q <= 8'd0;
      s_q        <= 2'b00;
      sym_q      <= 2'b00;
      valid_q    <= 1'b0;
      fs_q       <= 1'b0;
      fe_q       <= 1'b0;
`ifdef CONV_ENC_TAIL_FLUSH_EN
      tail_cnt_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      byte_q     <= byte_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      s_q        <= s_d;
      sym_q      <= sym_d;
      valid_q    <= valid_d;
      fs_q       <= fs_d;
      fe_q       <= fe_d;
`ifdef CONV_ENC_TAIL_FLUSH_EN
      tail_cnt_q <= tail_cnt_d;
`endif
    end
  end

endmodule
